// File: rtl/key_event_queue.sv
// key_event_queue
// Turns the PS/2 controller's level outputs (keycode + held keypress) into
// discrete press/release events, buffers them in a show-ahead FIFO and
// presents the head event over a valid/ready handshake. Events that arrive
// while the FIFO is full are dropped and flagged by a sticky overflow bit.
//
// Optional build macro: KEY_EVT_TIMESTAMP_EN
//   When defined, each event is tagged with a TS_W-bit tick count
//   (one tick per TS_DIV clk cycles) and the head tag appears on evt_time.

module key_event_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
`ifdef KEY_EVT_TIMESTAMP_EN
  ,
  parameter int TS_W   = 16,
  parameter int TS_DIV = 50000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        keycode,
  input  logic              keypress,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [7:0]        evt_code,
  output logic              evt_press,
  output logic [ADDR_W:0]   evt_count,
  output logic              overflow,
  input  logic              ovf_clr
`ifdef KEY_EVT_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]   evt_time
`endif
);

  logic              prev_press;
  logic [7:0]        prev_code;

  logic              det_valid;
  logic              det_press;
  logic [7:0]        det_code;

  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              drop;

  logic [7:0]        mem_code  [DEPTH];
  logic              mem_press [DEPTH];

  // Edge detect between current inputs and last cycle's; release has priority.
  always_comb begin
    det_valid = 1'b0;
    det_press = 1'b0;
    det_code  = keycode;
    if (prev_press && !keypress) begin
      det_valid = 1'b1;
      det_press = 1'b0;
      det_code  = prev_code;
    end else if (!prev_press && keypress) begin
      det_valid = 1'b1;
      det_press = 1'b1;
    end else if (prev_press && keypress && (keycode != prev_code)) begin
      det_valid = 1'b1;
      det_press = 1'b1;
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                 (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign pop  = !empty && evt_ready;
  assign push = det_valid && (!full || pop);
  assign drop = det_valid && full && !pop;

  // Pointers, input history and sticky overflow (a new drop beats a clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      overflow   <= 1'b0;
      prev_press <= 1'b0;
      prev_code  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
      prev_press <= keypress;
      prev_code  <= keycode;
    end
  end

  // Event storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_code[wptr[ADDR_W-1:0]]  <= det_code;
      mem_press[wptr[ADDR_W-1:0]] <= det_press;
    end
  end

  // Head is read straight from storage and forced to zero while empty.
  assign evt_valid = !empty;
  assign evt_code  = empty ? 8'h00 : mem_code[rptr[ADDR_W-1:0]];
  assign evt_press = empty ? 1'b0  : mem_press[rptr[ADDR_W-1:0]];
  assign evt_count = wptr - rptr;

`ifdef KEY_EVT_TIMESTAMP_EN
  localparam int PS_W = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
  localparam logic [PS_W-1:0] PS_RELOAD = PS_W'(TS_DIV - 1);

  logic [PS_W-1:0] ps_cnt;
  logic [TS_W-1:0] ts_tick;
  logic [TS_W-1:0] mem_ts [DEPTH];

  // Prescaler counts down from TS_DIV-1; reaching zero advances the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_cnt  <= PS_RELOAD;
      ts_tick <= '0;
    end else if (ps_cnt == '0) begin
      ps_cnt  <= PS_RELOAD;
      ts_tick <= ts_tick + 1'b1;
    end else begin
      ps_cnt  <= ps_cnt - 1'b1;
    end
  end

  // Timestamp captured alongside the event it belongs to.
  always_ff @(posedge clk) begin
    if (push) mem_ts[wptr[ADDR_W-1:0]] <= ts_tick;
  end

  assign evt_time = empty ? '0 : mem_ts[rptr[ADDR_W-1:0]];
`endif

endmodule
